// File: rtl/branch_resolve_tracker_pkg.sv
// Shared types for the branch resolve tracker: BTB field widths, tracker FIFO entry and the
// 2-bit saturating history update.
package branch_resolve_tracker_pkg;

    typedef logic [31:0] word_t;
    typedef logic [27:0] btb_tag_t;
    typedef logic [29:0] btb_tgt_t;
    typedef logic [1:0]  btb_hist_t;

    localparam btb_hist_t HIST_STRONG_T  = 2'b11;
    localparam btb_hist_t HIST_STRONG_NT = 2'b00;

    typedef struct packed {
        word_t     pc;
        logic      hit;
        btb_hist_t history;
        btb_tgt_t  target;
        logic      predict_taken;
    } tracker_entry_t;

    function automatic btb_hist_t hist_update(input btb_hist_t hist, input logic taken);
        if (taken) begin
            return (hist == HIST_STRONG_T) ? hist : hist + 2'b01;
        end
        return (hist == HIST_STRONG_NT) ? hist : hist - 2'b01;
    endfunction

endpackage

// File: rtl/branch_pred_fifo.sv
// In-order FIFO of outstanding branch predictions; clear has priority over push and pop.
module branch_pred_fifo
    import branch_resolve_tracker_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = tracker_entry_t
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   clear,
    output entry_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push_en;
    logic               pop_en;

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        push_en   = push & ~full;
        pop_en    = pop & ~empty;
        pop_data  = mem_q[rd_ptr_q];
        occupancy = count_q;
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_tracker.sv
// Turns BTB lookups into predictions, tracks them until resolve, flags mispredicts and drives
// the BTB write port. Optional macro PRED_FWD_EN forwards the in-flight BTB write into lookups.
module branch_resolve_tracker
    import branch_resolve_tracker_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter btb_hist_t   HIST_INIT = 2'b10
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   lookup_valid,
    input  logic [31:0]            lookup_pc,
    output logic                   lookup_ready,
    input  logic                   btb_hit,
    input  logic [29:0]            btb_target,
    input  logic [1:0]             btb_history,
    output logic                   predict_taken,
    output logic [31:0]            predict_pc,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    input  logic [31:0]            resolve_target,
    input  logic                   flush,
    output logic                   mispredict,
    output logic [31:0]            redirect_pc,
    output logic                   btb_wen,
    output logic [1:0]             mapping_wsel,
    output logic [27:0]            tag_bits_new,
    output logic [29:0]            target_address_new,
    output logic                   slot_enabled,
    output logic [1:0]             branch_history_new,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   underflow
);

    logic           eff_hit;
    btb_tgt_t       eff_target;
    btb_hist_t      eff_hist;
    tracker_entry_t new_entry;
    tracker_entry_t head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           clear;
    logic           mis;
    logic           do_write;
    btb_tgt_t       wr_target;
    btb_hist_t      wr_hist;
    word_t          redirect_d;

    logic           mispredict_q;
    word_t          redirect_q;
    logic           btb_wen_q;
    logic [1:0]     wsel_q;
    btb_tag_t       tag_q;
    btb_tgt_t       target_q;
    btb_hist_t      hist_q;
    logic           underflow_q;

`ifdef PRED_FWD_EN
    logic fwd;
    // A write landing this cycle on the same slot supersedes the stale BTB read.
    always_comb begin
        fwd        = btb_wen && (mapping_wsel == lookup_pc[3:2]);
        eff_hit    = fwd ? (tag_bits_new == lookup_pc[31:4]) : btb_hit;
        eff_target = fwd ? target_address_new : btb_target;
        eff_hist   = fwd ? branch_history_new : btb_history;
    end
`else
    always_comb begin
        eff_hit    = btb_hit;
        eff_target = btb_target;
        eff_hist   = btb_history;
    end
`endif

    always_comb begin
        predict_taken = eff_hit & eff_hist[1];
        predict_pc    = predict_taken ? {eff_target, 2'b00} : lookup_pc + 32'd4;
        lookup_ready  = ~full;
        new_entry     = '{pc: lookup_pc, hit: eff_hit, history: eff_hist,
                          target: eff_target, predict_taken: predict_taken};

        pop   = resolve_valid & ~empty;
        mis   = pop & ((head.predict_taken != resolve_taken) ||
                       (head.predict_taken && resolve_taken &&
                        ({head.target, 2'b00} != resolve_target)));
        clear = flush | mis;
        // Anything fetched alongside a mispredict or flush is wrong-path.
        push  = lookup_valid & lookup_ready & ~clear;

        do_write   = pop & (head.hit | resolve_taken);
        wr_target  = (head.hit & ~resolve_taken) ? head.target : resolve_target[31:2];
        wr_hist    = head.hit ? hist_update(head.history, resolve_taken) : HIST_INIT;
        redirect_d = resolve_taken ? resolve_target : head.pc + 32'd4;
    end

    branch_pred_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (tracker_entry_t)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (new_entry),
        .pop       (pop),
        .clear     (clear),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            btb_wen_q    <= 1'b0;
            wsel_q       <= '0;
            tag_q        <= '0;
            target_q     <= '0;
            hist_q       <= '0;
            underflow_q  <= 1'b0;
        end else begin
            mispredict_q <= mis;
            btb_wen_q    <= do_write;
            underflow_q  <= underflow_q | (resolve_valid & empty);
            if (pop) begin
                redirect_q <= redirect_d;
            end
            if (do_write) begin
                wsel_q   <= head.pc[3:2];
                tag_q    <= head.pc[31:4];
                target_q <= wr_target;
                hist_q   <= wr_hist;
            end
        end
    end

    always_comb begin
        mispredict         = mispredict_q;
        redirect_pc        = redirect_q;
        btb_wen            = btb_wen_q;
        slot_enabled       = btb_wen_q;
        mapping_wsel       = wsel_q;
        tag_bits_new       = tag_q;
        target_address_new = target_q;
        branch_history_new = hist_q;
        underflow          = underflow_q;
    end

endmodule
